// File: rtl/mux_scan_ctrl.sv
// Scan sequencer around a 4:1 mux: steps sel over the enabled channels, samples mux_y
// after a programmable dwell, and hands the assembled 4-bit word off on valid/ready.
module mux_scan_ctrl #(
  parameter int unsigned DWELL = 1,
  parameter int unsigned CNT_W = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] ch_mask,
  output logic [1:0] sel,
  input  logic       mux_y,
  output logic       busy,
  output logic [3:0] data_out,
  output logic       valid,
  input  logic       ready
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);

  state_t           r_state;
  logic [3:0]       r_mask;
  logic [3:0]       r_shadow;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_sel;
  logic             r_busy;
  logic             r_valid;
  logic [3:0]       r_data;

  logic [2:0]       w_first;
  logic [2:0]       w_next;
  logic [3:0]       w_shadow_smp;
  logic             w_dwell_end;

  // Returns {found, index} of the lowest enabled channel above cur (or at cur when incl).
  function automatic logic [2:0] f_next_ch(input logic [3:0] mask, input logic [1:0] cur,
                                           input logic incl);
    logic [2:0] res;
    res = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      if (mask[i] && ((i > int'(cur)) || (incl && (i == int'(cur)))))
        res = {1'b1, 2'(i)};
    end
    return res;
  endfunction

  always_comb begin
    w_first      = f_next_ch(ch_mask, 2'd0, 1'b1);
    w_next       = f_next_ch(r_mask, r_sel, 1'b0);
    w_dwell_end  = (r_cnt == DWELL_LAST);
    w_shadow_smp = r_shadow;
    w_shadow_smp[r_sel] = mux_y;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_mask   <= 4'b0000;
      r_shadow <= 4'b0000;
      r_cnt    <= '0;
      r_sel    <= 2'd0;
      r_busy   <= 1'b0;
      r_valid  <= 1'b0;
      r_data   <= 4'b0000;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mask   <= ch_mask;
            r_shadow <= 4'b0000;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            if (ch_mask != 4'b0000) begin
              r_state <= S_SCAN;
              r_sel   <= w_first[1:0];
            end else begin
              // Empty scan: word is zero, valid rises one cycle after entering DONE.
              r_state <= S_DONE;
              r_data  <= 4'b0000;
            end
          end
        end
        S_SCAN: begin
          if (w_dwell_end) begin
            r_shadow <= w_shadow_smp;
            r_cnt    <= '0;
            if (w_next[2]) begin
              r_sel <= w_next[1:0];
            end else begin
              r_state <= S_DONE;
              r_sel   <= 2'd0;
              r_data  <= w_shadow_smp;
              r_valid <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_DONE: begin
          if (r_valid && ready) begin
            r_state <= S_IDLE;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
          end else begin
            r_valid <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign sel      = r_sel;
  assign busy     = r_busy;
  assign valid    = r_valid;
  assign data_out = r_data;

endmodule
